// File: rtl/free_list_pkg.sv
// Shared types and default sizing for the multi-way physical-register free list.
// Bit i of a bitmap set means physical register i is free.
package free_list_pkg;

    localparam int FL_NUM_PR       = 64;
    localparam int FL_NUM_RESERVED = 32;
    localparam int FL_ALLOC_WIDTH  = 2;
    localparam int FL_FREE_WIDTH   = 2;
    localparam int FL_NUM_CKPT     = 4;
    localparam int FL_PR_W         = $clog2(FL_NUM_PR);
    localparam int FL_CKPT_W       = $clog2(FL_NUM_CKPT);

    typedef logic [FL_PR_W-1:0]   pr_idx_t;
    typedef logic [FL_CKPT_W-1:0] ckpt_id_t;
    typedef logic [FL_NUM_PR-1:0] bitmap_t;

    // Registers below NUM_RESERVED hold the initial architectural map.
    localparam bitmap_t RESET_BITMAP = ~bitmap_t'(0) << FL_NUM_RESERVED;

endpackage

// File: rtl/pr_select_n.sv
// N-way find-first-set: returns the indices of the N lowest set bits of a bitmap.
// Purely combinational.
module pr_select_n #(
    parameter int NUM_BITS = 64,
    parameter int N        = 2,
    parameter int IDX_W    = $clog2(NUM_BITS)
) (
    input  logic [NUM_BITS-1:0]     bitmap,
    output logic [N-1:0][IDX_W-1:0] idx,
    output logic [N-1:0]            valid
);

    logic [NUM_BITS-1:0] remaining;

    // Each way takes the lowest remaining set bit, then hides it from later ways.
    always_comb begin
        remaining = bitmap;
        idx       = '0;
        valid     = '0;
        for (int k = 0; k < N; k++) begin
            for (int i = NUM_BITS - 1; i >= 0; i--) begin
                if (remaining[i]) begin
                    idx[k]   = IDX_W'(i);
                    valid[k] = 1'b1;
                end
            end
            if (valid[k]) begin
                remaining[idx[k]] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/free_list_mw.sv
// Multi-way physical-register free list with branch checkpoints and flush recovery.
// Grants the lowest-index free PRs; all updates become visible the following cycle.
module free_list_mw
    import free_list_pkg::*;
#(
    parameter int NUM_PR       = FL_NUM_PR,
    parameter int NUM_RESERVED = FL_NUM_RESERVED,
    parameter int ALLOC_WIDTH  = FL_ALLOC_WIDTH,
    parameter int FREE_WIDTH   = FL_FREE_WIDTH,
    parameter int NUM_CKPT     = FL_NUM_CKPT,
    parameter int PR_W         = $clog2(NUM_PR),
    parameter int CKPT_W       = $clog2(NUM_CKPT)
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic [ALLOC_WIDTH-1:0]            alloc_valid,
    output logic [ALLOC_WIDTH-1:0][PR_W-1:0]  alloc_pr,
    input  logic [ALLOC_WIDTH-1:0]            alloc_en,
    input  logic [FREE_WIDTH-1:0]             free_en,
    input  logic [FREE_WIDTH-1:0][PR_W-1:0]   free_pr,
    input  logic                              ckpt_save_en,
    input  logic [CKPT_W-1:0]                 ckpt_save_id,
    input  logic                              ckpt_restore_en,
    input  logic [CKPT_W-1:0]                 ckpt_restore_id,
    input  logic                              flush_en,
    input  logic [NUM_PR-1:0]                 flush_mask,
    output logic [PR_W:0]                     free_count,
    output logic                              is_empty
);

    localparam logic [NUM_PR-1:0] RESET_BM = {NUM_PR{1'b1}} << NUM_RESERVED;

    logic [NUM_PR-1:0] bitmap;
    logic [NUM_PR-1:0] bitmap_next;
    logic [NUM_PR-1:0] granted;
    logic [NUM_PR-1:0] freed;
    logic [NUM_PR-1:0] snap [NUM_CKPT];
    logic              normal_cycle;

    function automatic logic [PR_W:0] popcount(input logic [NUM_PR-1:0] v);
        logic [PR_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_PR; i++) begin
            c = c + (PR_W+1)'(v[i]);
        end
        return c;
    endfunction

    pr_select_n #(
        .NUM_BITS (NUM_PR),
        .N        (ALLOC_WIDTH),
        .IDX_W    (PR_W)
    ) u_select (
        .bitmap (bitmap),
        .idx    (alloc_pr),
        .valid  (alloc_valid)
    );

    assign is_empty     = (free_count == '0);
    assign normal_cycle = !flush_en && !ckpt_restore_en;

    // Grants only happen on normal cycles; slots without a free PR are ignored.
    always_comb begin
        granted = '0;
        freed   = '0;
        if (normal_cycle) begin
            for (int k = 0; k < ALLOC_WIDTH; k++) begin
                if (alloc_en[k] && alloc_valid[k]) begin
                    granted[alloc_pr[k]] = 1'b1;
                end
            end
        end
        for (int j = 0; j < FREE_WIDTH; j++) begin
            if (free_en[j]) begin
                freed[free_pr[j]] = 1'b1;
            end
        end
    end

    always_comb begin
        if (flush_en) begin
            bitmap_next = bitmap | flush_mask | freed;
        end else if (ckpt_restore_en) begin
            bitmap_next = snap[ckpt_restore_id] | freed;
        end else begin
            bitmap_next = (bitmap & ~granted) | freed;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitmap     <= RESET_BM;
            free_count <= (PR_W+1)'(NUM_PR - NUM_RESERVED);
        end else begin
            bitmap     <= bitmap_next;
            free_count <= popcount(bitmap_next);
        end
    end

    // Retired frees land in every snapshot so a later restore never loses them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CKPT; c++) begin
                snap[c] <= RESET_BM;
            end
        end else begin
            for (int c = 0; c < NUM_CKPT; c++) begin
                if (normal_cycle && ckpt_save_en && (ckpt_save_id == CKPT_W'(c))) begin
                    snap[c] <= bitmap_next;
                end else begin
                    snap[c] <= snap[c] | freed;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < FREE_WIDTH; j++) begin
                if (free_en[j]) begin
                    assert (!bitmap[free_pr[j]]);
                    assert (!granted[free_pr[j]]);
                    for (int m = j + 1; m < FREE_WIDTH; m++) begin
                        if (free_en[m]) begin
                            assert (free_pr[j] != free_pr[m]);
                        end
                    end
                end
            end
            assert ((alloc_en & (alloc_en + 1'b1)) == '0);
            for (int k = 0; k < ALLOC_WIDTH; k++) begin
                if (normal_cycle && alloc_en[k]) begin
                    assert (alloc_valid[k]);
                end
            end
        end
    end

endmodule

// File: tb/tb_free_list_mw.sv
// Bench for free_list_mw: directed recovery scenarios, then randomized traffic
// checked against a set-based reference model of the free list.
module tb_free_list_mw;

    localparam int NUM_PR       = 8;
    localparam int NUM_RESERVED = 4;
    localparam int AW           = 2;
    localparam int FW           = 2;
    localparam int NUM_CKPT     = 2;
    localparam int PR_W         = $clog2(NUM_PR);
    localparam int CKPT_W       = $clog2(NUM_CKPT);

    logic                     clk = 1'b0;
    logic                     reset;
    logic [AW-1:0]            alloc_valid;
    logic [AW-1:0][PR_W-1:0]  alloc_pr;
    logic [AW-1:0]            alloc_en;
    logic [FW-1:0]            free_en;
    logic [FW-1:0][PR_W-1:0]  free_pr;
    logic                     ckpt_save_en;
    logic [CKPT_W-1:0]        ckpt_save_id;
    logic                     ckpt_restore_en;
    logic [CKPT_W-1:0]        ckpt_restore_id;
    logic                     flush_en;
    logic [NUM_PR-1:0]        flush_mask;
    logic [PR_W:0]            free_count;
    logic                     is_empty;

    int nchecks = 0;
    int nerrors = 0;

    bit m_free [NUM_PR];
    bit m_snap [NUM_CKPT][NUM_PR];

    free_list_mw #(
        .NUM_PR       (NUM_PR),
        .NUM_RESERVED (NUM_RESERVED),
        .ALLOC_WIDTH  (AW),
        .FREE_WIDTH   (FW),
        .NUM_CKPT     (NUM_CKPT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_valid     (alloc_valid),
        .alloc_pr        (alloc_pr),
        .alloc_en        (alloc_en),
        .free_en         (free_en),
        .free_pr         (free_pr),
        .ckpt_save_en    (ckpt_save_en),
        .ckpt_save_id    (ckpt_save_id),
        .ckpt_restore_en (ckpt_restore_en),
        .ckpt_restore_id (ckpt_restore_id),
        .flush_en        (flush_en),
        .flush_mask      (flush_mask),
        .free_count      (free_count),
        .is_empty        (is_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        nchecks++;
        if (obs != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        alloc_en        = '0;
        free_en         = '0;
        free_pr         = '0;
        ckpt_save_en    = 1'b0;
        ckpt_save_id    = '0;
        ckpt_restore_en = 1'b0;
        ckpt_restore_id = '0;
        flush_en        = 1'b0;
        flush_mask      = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_PR; i++) begin
            m_free[i] = (i >= NUM_RESERVED);
            for (int c = 0; c < NUM_CKPT; c++) m_snap[c][i] = (i >= NUM_RESERVED);
        end
    endtask

    // Next state from the rules: the lowest free PRs are handed out in order,
    // frees are set-insertions applied to the live list and every snapshot.
    task automatic model_step();
        bit nxt [NUM_PR];
        bit fr  [NUM_PR];
        int seen;
        for (int i = 0; i < NUM_PR; i++) fr[i] = 0;
        for (int j = 0; j < FW; j++) if (free_en[j]) fr[free_pr[j]] = 1;
        seen = 0;
        for (int i = 0; i < NUM_PR; i++) begin
            if (flush_en)             nxt[i] = m_free[i] | flush_mask[i];
            else if (ckpt_restore_en) nxt[i] = m_snap[ckpt_restore_id][i];
            else begin
                nxt[i] = m_free[i];
                if (m_free[i]) begin
                    if (seen < AW && alloc_en[seen]) nxt[i] = 0;
                    seen++;
                end
            end
            nxt[i] = nxt[i] | fr[i];
        end
        for (int c = 0; c < NUM_CKPT; c++) begin
            for (int i = 0; i < NUM_PR; i++) begin
                if (!flush_en && !ckpt_restore_en && ckpt_save_en && ckpt_save_id == CKPT_W'(c))
                    m_snap[c][i] = nxt[i];
                else
                    m_snap[c][i] = m_snap[c][i] | fr[i];
            end
        end
        for (int i = 0; i < NUM_PR; i++) m_free[i] = nxt[i];
    endtask

    task automatic check_model(input string tag);
        int fl[$];
        for (int i = 0; i < NUM_PR; i++) if (m_free[i]) fl.push_back(i);
        chk({tag, ".count"}, free_count, fl.size());
        chk({tag, ".empty"}, is_empty, (fl.size() == 0) ? 1 : 0);
        for (int k = 0; k < AW; k++) begin
            chk($sformatf("%s.valid%0d", tag, k), alloc_valid[k], (k < fl.size()) ? 1 : 0);
            if (k < fl.size()) chk($sformatf("%s.pr%0d", tag, k), alloc_pr[k], fl[k]);
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        idle();
        check_model(tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".pr0"}, alloc_pr[0], 4);
        chk({tag, ".pr1"}, alloc_pr[1], 5);
        chk({tag, ".valid"}, alloc_valid, 3);
        chk({tag, ".count"}, free_count, 4);
        chk({tag, ".empty"}, is_empty, 0);
    endtask

    initial begin
        int fl[$];
        int q[$];
        int r, n, idx;

        reset = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_reset_values("rst");

        alloc_en = 2'b11;
        tick("alloc1");
        chk("alloc1.pr0", alloc_pr[0], 6);
        chk("alloc1.pr1", alloc_pr[1], 7);
        chk("alloc1.cnt", free_count, 2);
        alloc_en = 2'b11;
        tick("alloc2");
        chk("alloc2.valid", alloc_valid, 0);
        chk("alloc2.empty", is_empty, 1);

        free_en = 2'b11;
        free_pr[0] = 3'd5;
        free_pr[1] = 3'd2;
        #1;
        chk("nobypass.valid", alloc_valid, 0);
        tick("refill");
        chk("refill.pr0", alloc_pr[0], 2);
        chk("refill.pr1", alloc_pr[1], 5);
        chk("refill.cnt", free_count, 2);

        reset = 1'b0;
        model_reset();
        #2 reset = 1'b1;
        #1;
        alloc_en = 2'b01;
        ckpt_save_en = 1'b1;
        ckpt_save_id = '0;
        tick("save");
        alloc_en = 2'b11;
        tick("alloc56");
        free_en = 2'b01;
        free_pr[0] = 3'd1;
        tick("free1");
        ckpt_restore_en = 1'b1;
        ckpt_restore_id = '0;
        tick("restore");
        chk("restore.pr0", alloc_pr[0], 1);
        chk("restore.pr1", alloc_pr[1], 5);
        chk("restore.cnt", free_count, 4);

        ckpt_restore_en = 1'b1;
        ckpt_restore_id = '0;
        alloc_en = 2'b11;
        free_en = 2'b01;
        free_pr[0] = 3'd3;
        tick("restore_free");
        chk("restore_free.cnt", free_count, 5);
        chk("restore_free.pr1", alloc_pr[1], 3);

        alloc_en = 2'b11;
        tick("drain1");
        alloc_en = 2'b11;
        tick("drain2");
        alloc_en = 2'b01;
        tick("drain3");
        chk("drain.cnt", free_count, 0);
        flush_en = 1'b1;
        flush_mask = 8'hF0;
        free_en = 2'b01;
        free_pr[0] = 3'd0;
        tick("flush");
        chk("flush.cnt", free_count, 5);
        chk("flush.pr0", alloc_pr[0], 0);
        chk("flush.pr1", alloc_pr[1], 4);

        #3 reset = 1'b0;
        model_reset();
        #1;
        check_reset_values("midrst");
        #1 reset = 1'b1;

        for (int cyc = 0; cyc < 400; cyc++) begin
            fl.delete();
            q.delete();
            for (int i = 0; i < NUM_PR; i++) begin
                if (m_free[i]) fl.push_back(i);
                else q.push_back(i);
            end
            r = $urandom_range(0, 99);
            if (r < 6) begin
                flush_en = 1'b1;
                flush_mask = NUM_PR'($urandom);
                n = $urandom_range(0, AW);
            end else if (r < 18) begin
                ckpt_restore_en = 1'b1;
                ckpt_restore_id = CKPT_W'($urandom_range(0, NUM_CKPT - 1));
                n = $urandom_range(0, AW);
            end else begin
                n = $urandom_range(0, (fl.size() < AW) ? fl.size() : AW);
                if ($urandom_range(0, 4) == 0) begin
                    ckpt_save_en = 1'b1;
                    ckpt_save_id = CKPT_W'($urandom_range(0, NUM_CKPT - 1));
                end
            end
            alloc_en = AW'((1 << n) - 1);
            for (int j = 0; j < FW; j++) begin
                if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    idx = $urandom_range(0, q.size() - 1);
                    free_en[j] = 1'b1;
                    free_pr[j] = PR_W'(q[idx]);
                    q.delete(idx);
                end
            end
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/free_list_mw.md
Name: free_list_mw

Overview:
- Multi-way physical-register free list for the rename stage.
- Grants up to ALLOC_WIDTH free PRs per cycle and accepts up to FREE_WIDTH released PRs per cycle from retirement.
- Keeps NUM_CKPT branch snapshots for single-cycle restore on mispredict, plus a mask-based flush for full-pipeline recovery.
- Bitmap-based: bit i set means PR i is free.

Parameters:
- NUM_PR, 64, number of physical registers.
- NUM_RESERVED, 32, PRs 0..NUM_RESERVED-1 start allocated (initial architectural map).
- ALLOC_WIDTH, 2, allocation ports per cycle.
- FREE_WIDTH, 2, release ports per cycle.
- NUM_CKPT, 4, branch checkpoint slots.
- PR_W, $clog2(NUM_PR), PR index width (derived).
- CKPT_W, $clog2(NUM_CKPT), checkpoint id width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- alloc_valid  out  ALLOC_WIDTH  bit k set when a k-th free PR exists.
- alloc_pr  out  ALLOC_WIDTH x PR_W  k-th lowest-index free PR.
- alloc_en  in  ALLOC_WIDTH  consume slot k; must be a prefix (thermometer from bit 0).
- free_en  in  FREE_WIDTH  release valid per port.
- free_pr  in  FREE_WIDTH x PR_W  PR being released.
- ckpt_save_en  in  1  snapshot the post-allocation bitmap.
- ckpt_save_id  in  CKPT_W  destination slot.
- ckpt_restore_en  in  1  restore bitmap from a slot.
- ckpt_restore_id  in  CKPT_W  source slot.
- flush_en  in  1  full recovery.
- flush_mask  in  NUM_PR  PRs to mark free on flush.
- free_count  out  PR_W+1  registered popcount of the bitmap.
- is_empty  out  1  free_count == 0.

Behaviour:
- Reset (reset low, async):
  - bitmap[i] = 0 for i < NUM_RESERVED, 1 otherwise.
  - All snapshots equal that value.
  - free_count = NUM_PR-NUM_RESERVED.
  - Outputs are valid in the first cycle after release.
- Selection (combinational from the registered bitmap):
  - alloc_pr[k] = index of the (k+1)-th set bit, scanning upward from 0.
  - alloc_valid[k] = (free_count > k).
  - alloc_pr[k] is don't-care when alloc_valid[k]=0.
- Update: one cycle. Granted/freed PRs are reflected in alloc_* and free_count on the next cycle. No same-cycle bypass of freed PRs to alloc_pr.
- Normal cycle (no flush, no restore):
  - bitmap_next = (bitmap & ~granted) | freed.
  - granted = alloc_pr[k] for each k with alloc_en[k] && alloc_valid[k]. Bits with alloc_en[k] && !alloc_valid[k] are ignored; assertion fires.
- Save: with ckpt_save_en, snapshot[ckpt_save_id] <= bitmap_next, so it includes this cycle's grants and frees. Save is ignored when restore or flush is asserted.
- Frees to snapshots: every freed PR is also OR'd into all snapshots every cycle, including flush and restore cycles. Retired frees are never lost.
- Restore: bitmap_next = snapshot[ckpt_restore_id] | freed. alloc_en is ignored that cycle.
- Flush: bitmap_next = bitmap | flush_mask | freed. alloc_en and restore are ignored that cycle.
- Priority: reset > flush > restore > normal/save.
- free_count register: loaded with popcount(bitmap_next).
- Assertions (simulation only):
  - free of an already-free PR.
  - free of a PR also granted this cycle.
  - alloc_en not a prefix.
  - two free ports naming the same PR.

Decomposition:
- Shared package free_list_pkg:
  - pr_idx_t (logic [PR_W-1:0]);
  - ckpt_id_t;
  - bitmap_t (logic [NUM_PR-1:0]);
  - reset bitmap constant derived from NUM_RESERVED.
- One sub-module, pr_select_n:
  - parametrised N-way find-first-set over bitmap_t;
  - outputs ALLOC_WIDTH indices and valid bits;
  - purely combinational, instantiated once.

Test Plan (NUM_PR=8, NUM_RESERVED=4, ALLOC_WIDTH=2, FREE_WIDTH=2, NUM_CKPT=2):
1. Release reset -> alloc_pr={4,5}, alloc_valid=11, free_count=4, is_empty=0.
2. alloc_en=11 twice -> after first: alloc_pr={6,7}, count 2; after second: alloc_valid=00, is_empty=1, count 0.
3. While empty, free_en=11 with free_pr={5,2} -> same cycle alloc_valid=00 (no bypass); next cycle alloc_pr={2,5}, count 2.
4. From reset: alloc_en=01 + save id0 (snapshot free={5,6,7}); alloc_en=11 (takes 5,6); free PR1; restore id0 -> bitmap free={1,5,6,7}, alloc_pr={1,5}, count 4.
5. Restore id0 with concurrent alloc_en=11 and free PR3 -> grants dropped; next cycle PR3 free and snapshot0 also has bit3 set.
6. After allocating all, flush_en with flush_mask=8'hF0 plus free PR0 -> bitmap=8'hF1, count 5. Then assert reset mid-cycle -> outputs return immediately to step-1 values.
